// File: rtl/riscv_pkg.sv
// Shared encodings for the integer pipeline: result select, load/store size codes, memory FSM states.
// No logic of its own; is_misaligned is the one alignment rule used by every stage that needs it.
package riscv_pkg;

   localparam logic [2:0] RES_SRC_ALU  = 3'b000;
   localparam logic [2:0] RES_SRC_LOAD = 3'b001;
   localparam logic [2:0] RES_SRC_PC4  = 3'b010;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RSP} mem_state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         FUNCT3_H, FUNCT3_HU: return addr_lo[0];
         FUNCT3_W:            return addr_lo != 2'b00;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: replicates store data across lanes with byte enables, extracts and extends load data.
// Purely combinational, zero latency; no flow control of its own.
// Backpressure: none; outputs follow inputs every cycle.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic        store_en,
   input  logic [31:0] load_word,
   input  logic        load_en,
   output logic [31:0] store_wdata,
   output logic [3:0]  store_be,
   output logic [31:0] load_data
);

   logic [7:0]  load_byte;
   logic [15:0] load_half;

   always_comb begin
      store_wdata = store_data;
      store_be    = 4'b1111;
      case (funct3)
         FUNCT3_B: begin
            store_wdata = {4{store_data[7:0]}};
            store_be    = 4'b0001 << addr_lo;
         end
         FUNCT3_H: begin
            store_wdata = {2{store_data[15:0]}};
            store_be    = 4'b0011 << {addr_lo[1], 1'b0};
         end
         default: ;
      endcase
      if (!store_en)
         store_be = 4'b0000;
   end

   always_comb begin
      case (addr_lo)
         2'd0:    load_byte = load_word[7:0];
         2'd1:    load_byte = load_word[15:8];
         2'd2:    load_byte = load_word[23:16];
         default: load_byte = load_word[31:24];
      endcase
      load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

      case (funct3)
         FUNCT3_B:  load_data = {{24{load_byte[7]}}, load_byte};
         FUNCT3_H:  load_data = {{16{load_half[15]}}, load_half};
         FUNCT3_BU: load_data = {24'd0, load_byte};
         FUNCT3_HU: load_data = {16'd0, load_half};
         default:   load_data = load_word;
      endcase
      // Writeback must not see stale memory data outside the completing cycle.
      if (!load_en)
         load_data = 32'd0;
   end

endmodule

// File: rtl/memory_stage.sv
// EX/MEM register plus data-memory valid/ready transaction for loads and stores.
// Latency: 1 cycle for non-memory ops and zero-wait stores; loads take >= 2 cycles.
// Backpressure: stall_m holds execute and upstream while a request or load response is outstanding.
module memory_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reg_write_e,
   input  logic [2:0]               res_src_e,
   input  logic                     mem_write_e,
   input  logic [2:0]               funct3_e,
   input  logic [DATA_WIDTH-1:0]    alu_result_e,
   input  logic [DATA_WIDTH-1:0]    write_data_e,
   input  logic [4:0]               rd_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
   input  logic                     flush_em,
   output logic                     stall_m,
   output logic                     dmem_req_valid,
   input  logic                     dmem_req_ready,
   output logic                     dmem_req_we,
   output logic [ADDRESS_WIDTH-1:0] dmem_req_addr,
   output logic [DATA_WIDTH-1:0]    dmem_req_wdata,
   output logic [3:0]               dmem_req_be,
   input  logic                     dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]    dmem_rsp_rdata,
   output logic                     misaligned_m,
   output logic                     wb_valid_m,
   output logic                     reg_write_m,
   output logic [2:0]               res_src_m,
   output logic [4:0]               rd_m,
   output logic [DATA_WIDTH-1:0]    alu_result_m,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
   output logic [DATA_WIDTH-1:0]    read_data_m
);

   typedef struct packed {
      logic                     reg_write;
      logic [2:0]               res_src;
      logic                     mem_write;
      logic [2:0]               funct3;
      logic [DATA_WIDTH-1:0]    alu_result;
      logic [DATA_WIDTH-1:0]    write_data;
      logic [4:0]               rd;
      logic [ADDRESS_WIDTH-1:0] pc_plus4;
   } exmem_t;

   exmem_t     q, d;
   mem_state_t state;
   logic       ex_go_req, held_mem_op, store_done, load_done;

   always_comb begin
      d = '0;
      if (!flush_em) begin
         d.reg_write  = reg_write_e;
         d.res_src    = res_src_e;
         d.mem_write  = mem_write_e;
         d.funct3     = funct3_e;
         d.alu_result = alu_result_e;
         d.write_data = write_data_e;
         d.rd         = rd_e;
         d.pc_plus4   = pc_plus4_e;
      end
   end

   assign ex_go_req = (d.mem_write || d.res_src == RES_SRC_LOAD)
                      && !is_misaligned(d.funct3, d.alu_result[1:0]);

   assign held_mem_op  = q.mem_write || q.res_src == RES_SRC_LOAD;
   assign misaligned_m = held_mem_op && is_misaligned(q.funct3, q.alu_result[1:0]);

   assign store_done = state == REQ && dmem_req_ready && q.mem_write;
   assign load_done  = state == RSP && dmem_rsp_valid;
   // REQ/RSP are only ever entered for an aligned memory op, so state alone says "op outstanding".
   assign stall_m    = (state == REQ && !store_done) || (state == RSP && !dmem_rsp_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         state <= IDLE;
      end else if (!stall_m) begin
         q     <= d;
         state <= ex_go_req ? REQ : IDLE;
      end else if (state == REQ && dmem_req_ready) begin
         state <= RSP;
      end
   end

   assign dmem_req_valid = state == REQ;
   assign dmem_req_we    = q.mem_write;
   assign dmem_req_addr  = {q.alu_result[ADDRESS_WIDTH-1:2], 2'b00};

   lsu_align u_lsu_align (
      .funct3      (q.funct3),
      .addr_lo     (q.alu_result[1:0]),
      .store_data  (q.write_data),
      .store_en    (q.mem_write),
      .load_word   (dmem_rsp_rdata),
      .load_en     (load_done),
      .store_wdata (dmem_req_wdata),
      .store_be    (dmem_req_be),
      .load_data   (read_data_m)
   );

   assign wb_valid_m   = !stall_m;
   assign reg_write_m  = q.reg_write && !misaligned_m;
   assign res_src_m    = q.res_src;
   assign rd_m         = q.rd;
   assign alu_result_m = q.alu_result;
   assign pc_plus4_m   = q.pc_plus4;

endmodule
